// File: rtl/usr_pkg.sv
// ============================================================================
// Module : usr_pkg
// Brief  : Mode encodings and parameter sanity helper for universal_shift_register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHR  = 2'b01;
  localparam logic [1:0] USR_SHL  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  // The shift counter must be able to represent WIDTH itself (its saturation value).
  function automatic bit usr_cnt_w_ok(input int width, input int cnt_w);
    return (width >= 2) && ((1 << cnt_w) > width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/usr_bit_cell.sv
// ============================================================================
// Module : usr_bit_cell
// Brief  : One register bit: 4:1 mux (hold/from-upper/from-lower/load) + DFF.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module usr_bit_cell
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_i,
  input  logic [1:0] sel_i,
  input  logic       shr_in_i,
  input  logic       shl_in_i,
  input  logic       d_i,
  output logic       q_o,
  output logic       notq_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case (sel_i)
      USR_SHR:  q_d = shr_in_i;
      USR_SHL:  q_d = shl_in_i;
      USR_LOAD: q_d = d_i;
      default:  q_d = q_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 1'b0;
    end else if (ce_i) begin
      q_q <= q_d;
    end
  end

  assign q_o    = q_q;
  assign notq_o = ~q_q;

endmodule

`default_nettype wire

// File: rtl/universal_shift_register.sv
// ============================================================================
// Module : universal_shift_register
// Brief  : WIDTH-bit hold/shift-right/shift-left/load register with saturating
//          shift counter. Define USR_ROTATE_EN to enable rotate via the rot input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             rot,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] notq,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shcnt,
  output logic             empty
);

  localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_FULL_M1 = CNT_W'(WIDTH - 1);

  if (!usr_cnt_w_ok(WIDTH, CNT_W)) begin : g_param_check
    $error("universal_shift_register: need WIDTH >= 2 and 2**CNT_W > WIDTH");
  end

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_notq;
  logic [WIDTH-1:0] w_shr_vec;
  logic [WIDTH-1:0] w_shl_vec;
  logic             w_msb_in;
  logic             w_lsb_in;

`ifdef USR_ROTATE_EN
  assign w_msb_in = rot ? w_q[0]       : sin_r;
  assign w_lsb_in = rot ? w_q[WIDTH-1] : sin_l;
`else
  // rot has no effect in this build; the masked term keeps the port formally used.
  assign w_msb_in = sin_r | (rot & 1'b0);
  assign w_lsb_in = sin_l;
`endif

  assign w_shr_vec = {w_msb_in, w_q[WIDTH-1:1]};
  assign w_shl_vec = {w_q[WIDTH-2:0], w_lsb_in};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    usr_bit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .ce_i     (ce),
      .sel_i    (mode),
      .shr_in_i (w_shr_vec[gi]),
      .shl_in_i (w_shl_vec[gi]),
      .d_i      (d[gi]),
      .q_o      (w_q[gi]),
      .notq_o   (w_notq[gi])
    );
  end

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             empty_q;
  logic             empty_d;

  always_comb begin
    cnt_d   = cnt_q;
    empty_d = empty_q;
    if (ce) begin
      case (mode)
        USR_LOAD: begin
          cnt_d   = '0;
          empty_d = 1'b0;
        end
        USR_SHR, USR_SHL: begin
          // Count saturates at WIDTH; data keeps moving regardless.
          if (cnt_q != C_FULL) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_FULL_M1) begin
              empty_d = 1'b1;
            end
          end
        end
        default: begin
          cnt_d   = cnt_q;
          empty_d = empty_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
    end
  end

  assign q      = w_q;
  assign notq   = w_notq;
  assign sout_r = w_q[0];
  assign sout_l = w_q[WIDTH-1];
  assign shcnt  = cnt_q;
  assign empty  = empty_q;

endmodule

`default_nettype wire

// File: tb/tb_universal_shift_register.sv
// ============================================================================
// Module : tb_universal_shift_register
// Brief  : Directed self-checking bench for universal_shift_register (WIDTH=8).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_r;
  logic       sin_l;
  logic       rot;
  logic [7:0] q;
  logic [7:0] notq;
  logic       sout_r;
  logic       sout_l;
  logic [3:0] shcnt;
  logic       empty;

  int errors = 0;
  int checks = 0;

  universal_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .mode   (mode),
    .d      (d),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .rot    (rot),
    .q      (q),
    .notq   (notq),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .shcnt  (shcnt),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_q;

    // Reset has priority over a load request
    rst = 1'b1; ce = 1'b1; mode = 2'b11; d = 8'hA5;
    sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;
    step();
    check("rst_q",     q,     8'h00);
    check("rst_notq",  notq,  8'hFF);
    check("rst_shcnt", shcnt, 4'd0);
    check("rst_empty", empty, 1'b0);

    // Load then hold via ce=0
    rst = 1'b0;
    step();
    check("load_q",     q,     8'hA5);
    check("load_notq",  notq,  8'h5A);
    check("load_shcnt", shcnt, 4'd0);
    ce = 1'b0; mode = 2'b01; sin_r = 1'b1;
    step(); step(); step();
    check("ce0_q",     q,     8'hA5);
    check("ce0_shcnt", shcnt, 4'd0);

    // Shift right x8 with sin_r=1; empty rises on the 8th shift
    ce = 1'b1;
    exp_q = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check("shr_sout_r", sout_r, exp_q[0]);
      step();
      exp_q = {1'b1, exp_q[7:1]};
      check("shr_q",     q,     exp_q);
      check("shr_shcnt", shcnt, i + 1);
      check("shr_empty", empty, (i == 7));
    end
    check("shr_final_q", q, 8'hFF);
    step();
    check("shr9_shcnt", shcnt, 4'd8);
    check("shr9_empty", empty, 1'b1);
    check("shr9_q",     q,     8'hFF);

    // Load while empty clears count; then one shift left
    mode = 2'b11; d = 8'h81;
    step();
    check("ld_empty_q",     q,     8'h81);
    check("ld_empty_shcnt", shcnt, 4'd0);
    check("ld_empty_empty", empty, 1'b0);
    check("shl_sout_l_pre", sout_l, 1'b1);
    mode = 2'b10; sin_l = 1'b0;
    step();
    check("shl_q",     q,     8'h02);
    check("shl_shcnt", shcnt, 4'd1);
    check("shl_notq",  notq,  8'hFD);

    // Reset mid-sequence
    mode = 2'b11; d = 8'h3C;
    step();
    mode = 2'b01; sin_r = 1'b0;
    step(); step(); step();
    check("mid_q",     q,     8'h07);
    check("mid_shcnt", shcnt, 4'd3);
    rst = 1'b1; ce = 1'b0;
    step();
    check("midrst_q",     q,     8'h00);
    check("midrst_notq",  notq,  8'hFF);
    check("midrst_shcnt", shcnt, 4'd0);
    check("midrst_empty", empty, 1'b0);
    rst = 1'b0; ce = 1'b1; mode = 2'b11; d = 8'h5A;
    step();
    check("post_rst_load", q, 8'h5A);

    // Rotate select (active only when USR_ROTATE_EN is defined)
    d = 8'h81;
    step();
    mode = 2'b01; rot = 1'b1; sin_r = 1'b0;
    step();
`ifdef USR_ROTATE_EN
    check("rot1_q", q, 8'hC0);
`else
    check("rot1_q", q, 8'h40);
`endif
    step(); step(); step(); step(); step(); step(); step();
`ifdef USR_ROTATE_EN
    check("rot8_q", q, 8'h81);
`else
    check("rot8_q", q, 8'h00);
`endif
    check("rot8_empty", empty, 1'b1);
    check("rot8_shcnt", shcnt, 4'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
